// File: rtl/spi_master_ctrl.sv
// SPI RAM master engine: frames one command as SETUP / SEND / (WAIT / RECV) / DONE on the system clock.
// Optional rd_data sequence check is built when SPI_MASTER_SEQ_CHECK_EN is defined.
module spi_master_ctrl #(
    parameter int FRAME_WIDTH = 8,
    parameter int READ_WAIT   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [FRAME_WIDTH-1:0] cmd_data,
    output logic                   rsp_valid,
    output logic [FRAME_WIDTH-1:0] rsp_data,
    output logic                   busy,
    output logic                   err,
    output logic                   SS_n,
    output logic                   MOSI,
    input  logic                   MISO
);
    localparam int CTRL_WIDTH = 3;
    localparam int TX_W       = FRAME_WIDTH + CTRL_WIDTH;
    localparam int MAX_CNT    = (TX_W > READ_WAIT) ? TX_W : READ_WAIT;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, RECV, DONE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TX_W-1:0]        tx_q;
    logic [FRAME_WIDTH-2:0] rx_q;
    logic [FRAME_WIDTH-1:0] rx_next;
    logic [FRAME_WIDTH-1:0] rsp_data_q;
    logic [1:0]             op_q;
    logic                   ss_q, mosi_q, rsp_valid_q;
    logic                   accept, reject;

    assign accept  = cmd_valid && cmd_ready;
    assign rx_next = {rx_q, MISO};
    assign cnt_d   = (state_d != state_q) ? '0 : cnt_q + 1'b1;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic rd_armed_q, err_q;

    // rd_data is only legal right after a completed rd_addr; otherwise bounce it without a frame.
    assign reject = accept && (cmd_op == OP_RD_DATA) && !rd_armed_q;
    assign err    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_armed_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= reject;
            if (state_q == DONE) rd_armed_q <= (op_q == OP_RD_ADDR);
        end
    end
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept && !reject) state_d = SETUP;
            SETUP: state_d = SEND;
            SEND: begin
                if (cnt_q == CNT_W'(TX_W - 1)) begin
                    if (op_q != OP_RD_DATA) state_d = DONE;
                    else if (READ_WAIT == 0) state_d = RECV;
                    else                     state_d = WAIT;
                end
            end
            WAIT:  if (cnt_q == CNT_W'(READ_WAIT - 1)) state_d = RECV;
            RECV:  if (cnt_q == CNT_W'(FRAME_WIDTH - 1)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
    end

    // Pin-side registers are loaded from the next state so SS_n/MOSI line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            tx_q        <= '0;
            op_q        <= 2'b00;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ss_q   <= (state_d == IDLE) || (state_d == DONE);
            mosi_q <= (state_d == SEND) && tx_q[TX_W-1];
            if (accept) begin
                // ctrl encoding: {op[1], op[1], op[0]}
                tx_q <= {cmd_op[1], cmd_op, cmd_data};
                op_q <= cmd_op;
            end else if (state_d == SEND) begin
                tx_q <= {tx_q[TX_W-2:0], 1'b0};
            end
            if (state_q == RECV) rx_q <= rx_next[FRAME_WIDTH-2:0];
            rsp_valid_q <= (state_q == RECV) && (state_d == DONE);
            if ((state_q == RECV) && (state_d == DONE)) rsp_data_q <= rx_next;
        end
    end

    assign SS_n      = ss_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: per-cycle timeline model of each frame plus an SPI RAM slave model.
module tb_spi_master_ctrl;
    localparam int FW   = 8;
    localparam int RW   = 2;
    localparam int TX_W = FW + 3;
    localparam int RS   = TX_W + 2 + RW;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [FW-1:0] cmd_data = '0;
    logic          rsp_valid, busy, err, SS_n, MOSI;
    logic [FW-1:0] rsp_data;
    logic          MISO = 1'b0;

    logic          v0 = 1'b0, rdy0, rv0, busy0, err0, ss0, mosi0;
    logic [1:0]    op0 = 2'b00;
    logic [FW-1:0] d0 = '0, rd0;
    logic          miso0 = 1'b0;

    spi_master_ctrl #(.FRAME_WIDTH(FW), .READ_WAIT(RW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err(err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));

    spi_master_ctrl #(.FRAME_WIDTH(FW), .READ_WAIT(0)) dut_rw0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0),
        .cmd_op(op0), .cmd_data(d0), .rsp_valid(rv0), .rsp_data(rd0),
        .busy(busy0), .err(err0), .SS_n(ss0), .MOSI(mosi0), .MISO(miso0));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: k = cycles since the accept edge (-1 when idle); SS_n low for cycles 1..llow, DONE at llow+1.
    int            k = -1, llow = 0, n_acc = 0;
    logic [1:0]    mop = 2'b00;
    logic [TX_W-1:0] mtx = '0;
    logic [FW-1:0] mrd = '0, exp_rsp = '0, slv_addr = '0;
    logic [FW-1:0] ram [256];
    bit            flag = 1'b0, err_pend = 1'b0, m_acc;

    initial for (int i = 0; i < 256; i++) ram[i] = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = -1; exp_rsp = '0; err_pend = 1'b0; flag = 1'b0;
        end else begin
            m_acc = cmd_valid && (k < 1);
            err_pend = 1'b0;
            if (k >= 1) begin
                k++;
                if (k == llow + 1) begin
                    case (mop)
                        2'b00, 2'b10: slv_addr = mtx[FW-1:0];
                        2'b01:        ram[slv_addr] = mtx[FW-1:0];
                        default:      exp_rsp = mrd;
                    endcase
                    flag = (mop == 2'b10);
                end else if (k > llow + 1) begin
                    k = -1;
                end
            end
            if (m_acc) begin
                n_acc++;
                if (SEQ && cmd_op == 2'b11 && !flag) begin
                    err_pend = 1'b1;
                end else begin
                    k    = 1;
                    mop  = cmd_op;
                    mtx  = {cmd_op[1], cmd_op, cmd_data};
                    llow = 1 + TX_W + ((cmd_op == 2'b11) ? RW + FW : 0);
                    mrd  = ram[slv_addr];
                end
            end
        end
    end

    int hi_run = 0;
    always @(negedge clk) begin
        chk("SS_n", SS_n, !(k >= 1 && k <= llow));
        chk("MOSI", MOSI, (k >= 2 && k <= TX_W + 1) ? mtx[TX_W+1-k] : 1'b0);
        chk("busy", busy, k >= 1);
        chk("cmd_ready", cmd_ready, !(k >= 1));
        chk("rsp_valid", rsp_valid, (k == llow + 1) && (mop == 2'b11));
        chk("rsp_data", rsp_data, exp_rsp);
        chk("err", err, err_pend);
        if (SS_n) hi_run++;
        else begin
            if (hi_run > 0) chk("ss_gap_ge2", hi_run >= 2, 1'b1);
            hi_run = 0;
        end
        if (mop == 2'b11 && k >= RS && k < RS + FW) MISO = mrd[FW-1-(k-RS)];
        else                                         MISO = 1'($urandom);
    end

    // Present a command at a negedge, wait for acceptance, return in cycle 1 with valid dropped and inputs scrambled.
    task automatic issue(input logic [1:0] op, input logic [FW-1:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL issue_timeout: cmd_ready never rose for op %0d", op);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = FW'($urandom);
    endtask

    task automatic capture(output logic [TX_W-1:0] bits, output int lows, output logic ss13);
        bits = '0; lows = 0; ss13 = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (!SS_n) lows++;
            if (c >= 2 && c <= 12) bits = {bits[TX_W-2:0], MOSI};
            ss13 = SS_n;
            if (c < 13) @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output int cyc);
        int c = 1;
        while (!rsp_valid && c < 60) begin @(negedge clk); c++; end
        cyc = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    logic [TX_W-1:0] bits;
    int              lows, cyc, n0, got;
    logic            ss13;
    logic [FW-1:0]   rdat, pat;
    logic [FW-1:0]   addrs [4];
    logic [1:0]      rop;
    logic [FW-1:0]   rdd;

    initial begin
        addrs[0] = 8'h10; addrs[1] = 8'h20; addrs[2] = 8'h33; addrs[3] = 8'h7F;
        repeat (2) @(negedge clk);
        chk("rst_SS_n", SS_n, 1'b1);
        chk("rst_MOSI", MOSI, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_err", err, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // wr_addr 0xA5 frame shape
        issue(2'b00, 8'hA5);
        capture(bits, lows, ss13);
        chk("t1_mosi_bits", bits, 11'b000_1010_0101);
        chk("t1_ss_low_cycles", lows, 12);
        chk("t1_ss_high_c13", ss13, 1'b1);

        // write then read back through the slave RAM
        issue(2'b00, 8'h10);
        issue(2'b01, 8'h5A);
        issue(2'b10, 8'h10);
        issue(2'b11, 8'hFF);
        wait_rsp(cyc);
        chk("t2_rsp_cycle", cyc, 23);
        chk("t2_rsp_data", rsp_data, 8'h5A);
        chk("t2_model_rsp", exp_rsp, 8'h5A);

        // back-to-back commands with cmd_valid held
        n0 = n_acc;
        issue(2'b00, 8'h20);
        issue(2'b01, 8'h99);
        issue(2'b10, 8'h20);
        issue(2'b11, 8'h00);
        issue(2'b00, 8'h44);
        chk("t3_accepts", n_acc - n0, 5);
        repeat (16) @(negedge clk);
        chk("t3_rsp_data", rsp_data, 8'h99);

        // reset in cycle 6 of a wr_data
        issue(2'b01, 8'h3C);
        repeat (5) @(negedge clk);
        chk("t4_pre_ss", SS_n, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_ss_now", SS_n, 1'b1);
        chk("t4_mosi_now", MOSI, 1'b0);
        chk("t4_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(2'b10, 8'h33);
        capture(bits, lows, ss13);
        chk("t4_rdaddr_bits", bits, 11'b110_0011_0011);
        chk("t4_ss_low_cycles", lows, 12);

        // READ_WAIT=0 instance, slave returns 0xC3
        pat = 8'hC3; got = 0; rdat = '0;
        v0 = 1'b1; op0 = 2'b10; d0 = 8'h07;
        @(posedge clk); @(negedge clk);
        v0 = 1'b0;
        repeat (15) @(negedge clk);
        v0 = 1'b1; op0 = 2'b11; d0 = 8'hFF;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            v0 = 1'b0;
            miso0 = (c >= 13 && c <= 20) ? pat[20-c] : 1'b0;
            if (rv0 && got == 0) begin got = c; rdat = rd0; end
        end
        chk("t5_rsp_cycle", got, 21);
        chk("t5_rsp_data", rdat, 8'hC3);

`ifdef SPI_MASTER_SEQ_CHECK_EN
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(2'b11, 8'h00);
        chk("t6_err_pulse", err, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk("t6_ss_high", SS_n, 1'b1);
            @(negedge clk);
        end
        issue(2'b10, 8'h07);
        issue(2'b11, 8'h00);
        wait_rsp(cyc);
        chk("t6_rsp_cycle", cyc, 23);
`endif

        // randomized command stream
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            rdd = (rop[0] == 1'b0) ? addrs[$urandom_range(0, 3)] : FW'($urandom);
            issue(rop, rdd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
